inst_rom_resp: RTL
==================

Name: inst_rom_resp

Overview:
- Instruction-memory responder: the ROM side of the fetch interface.
- Accepts PC requests on a valid/ready handshake and returns the instruction word a fixed LATENCY cycles later as a one-cycle valid pulse with data.
- The fetch unit has no response backpressure, so every accepted request yields exactly one response.
- A load port fills the array from the testbench or boot loader; a small FSM gates request acceptance around reset and load.

Parameters:
- ADDR_WIDTH, 32: request byte-address width.
- DATA_WIDTH, 32: instruction word width.
- DEPTH_LOG2, 10: log2 of array depth in words (1024 words = 4 KiB).
- LATENCY, 2: cycles from request acceptance to response; legal range 1..4.
- NOP_WORD, 32'h00000013: data returned on an errored request.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_send_valid_i  in  1  request valid from fetch.
- pc_i  in  ADDR_WIDTH  request byte address.
- pc_receive_ready_o  out  1  responder can accept a request this cycle.
- inst_valid_o  out  1  response valid, one-cycle pulse per accepted request.
- inst_data_o  out  DATA_WIDTH  instruction word; 0 whenever inst_valid_o=0.
- inst_err_o  out  1  response is for a misaligned or out-of-range address; qualified by inst_valid_o.
- load_mode_i  in  1  requests the LOAD state.
- wr_en_i  in  1  array write strobe; honoured only in LOAD.
- wr_addr_i  in  DEPTH_LOG2  word address for the write.
- wr_data_i  in  DATA_WIDTH  write data.

Behaviour:
- Interface decision: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values (rst=1 at a rising edge):
  - FSM goes to WAKE; all pipeline valid bits clear.
  - pc_receive_ready_o=0, inst_valid_o=0, inst_data_o=0, inst_err_o=0.
  - Array contents are not reset.
  - Reset mid-operation discards all in-flight responses; none is emitted after the reset edge.
- FSM states:
  - WAKE: ready=0. Lasts exactly one cycle after rst deasserts, then goes to LOAD if load_mode_i=1, else RUN.
  - RUN: ready=1. load_mode_i=1 moves to LOAD at the next edge; the cycle in which load_mode_i is seen still has ready=1.
  - LOAD: ready=0. Writes performed. load_mode_i=0 moves to RUN at the next edge.
- pc_receive_ready_o is a registered decode of state: 1 only in RUN.
- Acceptance is pc_send_valid_i & pc_receive_ready_o at a rising edge. Valid with ready=0 is not accepted and not remembered; the requester must hold it.
- Address decode, done in the acceptance cycle:
  - Misaligned when pc_i[1:0]!=0.
  - Out of range when pc_i[ADDR_WIDTH-1:DEPTH_LOG2+2]!=0.
  - Otherwise word index = pc_i[DEPTH_LOG2+1:2].
- Array read happens in the acceptance cycle. The word, or NOP_WORD with err=1, enters stage 1 of a LATENCY-deep shift pipeline of {valid, err, data}.
- Later writes never alter a request already in flight.
- Latency: a request accepted at edge N produces inst_valid_o=1 in the cycle following edge N+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- Back-to-back requests accepted every cycle produce a response every cycle, in order.
- Pipeline stages keep shifting in every state, so in-flight requests drain normally into WAKE→RUN or RUN→LOAD transitions. Only rst flushes them.
- Writes: in LOAD with wr_en_i=1, mem[wr_addr_i] <= wr_data_i at the edge. wr_en_i is ignored outside LOAD.
- Outputs:
  - inst_data_o and inst_err_o are forced to 0 when the last stage is not valid.
  - inst_err_o=1 implies inst_data_o=NOP_WORD.
- Simultaneous events:
  - rst has priority over everything.
  - The cycle load_mode_i rises in RUN still accepts a request.
  - The first write is honoured on the cycle after LOAD is entered.

Test Plan:
- Reset then idle, load_mode_i=0 → ready=0 in the first cycle after rst falls, ready=1 from the second. inst_valid_o stays 0.
- LOAD writes mem[0]=32'h00500093 and mem[1]=32'h00100113, exit to RUN, request pc=0x0 then 0x4 on consecutive cycles with LATENCY=2 → valid pulses 2 and 3 cycles after the first acceptance, carrying those words, err=0.
- Request pc=0x6 → data 32'h00000013, err=1. Request pc=0x1000 with DEPTH_LOG2=10 → data 32'h00000013, err=1.
- Accept pc=0x0, raise load_mode_i the next cycle, write mem[0]=32'hDEADBEEF → response for the in-flight request still returns 32'h00500093. ready=0 while in LOAD.
- Hold valid with pc=0x4 through WAKE → no acceptance while ready=0. Exactly one response follows the first ready=1 cycle.
- Accept 3 back-to-back requests with LATENCY=4, assert rst 2 cycles later → no inst_valid_o pulse after the reset edge. All outputs are 0.

Source files
------------

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction ROM responder with load port and fixed-latency response pipeline
module inst_rom_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_send_valid_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  pc_receive_ready_o,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  output logic                  inst_err_o,
  input  logic                  load_mode_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);
  typedef enum logic [1:0] {WAKE, RUN, LOAD} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [LATENCY-1:0] vld, err;
  logic [DATA_WIDTH-1:0] dat [LATENCY];
  logic acc, bad;
  always_comb begin
    state_n = load_mode_i ? LOAD : RUN;
    acc = pc_send_valid_i & pc_receive_ready_o;
    bad = (|pc_i[1:0]) | (|(pc_i >> (DEPTH_LOG2 + 2)));
  end
  always_ff @(posedge clk) begin
    state <= rst ? WAKE : state_n;
    pc_receive_ready_o <= ~rst & (state_n == RUN);
  end
  always_ff @(posedge clk) begin
    if (~rst & wr_en_i & (state == LOAD)) mem[wr_addr_i] <= wr_data_i;
  end
  always_ff @(posedge clk) begin
    vld[0] <= ~rst & acc;
    err[0] <= bad;
    dat[0] <= bad ? NOP_WORD : mem[pc_i[DEPTH_LOG2+1:2]];
    for (int i = 1; i < LATENCY; i++) begin
      vld[i] <= ~rst & vld[i-1];
      err[i] <= err[i-1];
      dat[i] <= dat[i-1];
    end
  end
  assign inst_valid_o = vld[LATENCY-1];
  assign inst_err_o = vld[LATENCY-1] & err[LATENCY-1];
  assign inst_data_o = vld[LATENCY-1] ? dat[LATENCY-1] : '0;
endmodule
